// File: rtl/ddr2_port_arbiter_if.sv
// Bus bundle between the two cache-side requesters, the arbiter and the DDR2 controller.
// master = requester/controller side, slave = arbiter.
interface ddr2_port_arbiter_if #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
);
    logic [ADDR_W-1:0] p0_addr;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p0_write_data;
    logic [DATA_W-1:0] p1_write_data;
    logic              p0_enable;
    logic              p1_enable;
    logic              p0_read;
    logic              p1_read;
    logic [DATA_W-1:0] p0_data;
    logic [DATA_W-1:0] p1_data;
    logic              p0_available;
    logic              p1_available;
    logic [1:0]        overflow;
    logic              busy;
    logic [ADDR_W-1:0] ddr2_addr;
    logic [DATA_W-1:0] to_ddr2_data;
    logic              ddr2_read;
    logic              ddr2_enable;
    logic              ddr2_available;
    logic [DATA_W-1:0] ddr2_data;

    modport master (
        output p0_addr, p1_addr,
        output p0_write_data, p1_write_data,
        output p0_enable, p1_enable,
        output p0_read, p1_read,
        input  p0_data, p1_data,
        input  p0_available, p1_available,
        input  overflow, busy,
        input  ddr2_addr, to_ddr2_data,
        input  ddr2_read, ddr2_enable,
        output ddr2_available, ddr2_data
    );

    modport slave (
        input  p0_addr, p1_addr,
        input  p0_write_data, p1_write_data,
        input  p0_enable, p1_enable,
        input  p0_read, p1_read,
        output p0_data, p1_data,
        output p0_available, p1_available,
        output overflow, busy,
        output ddr2_addr, to_ddr2_data,
        output ddr2_read, ddr2_enable,
        input  ddr2_available, ddr2_data
    );
endinterface

// File: rtl/ddr2_port_arbiter.sv
// Two-port round-robin arbiter onto one DDR2 request channel.
// One transaction outstanding; read data routed back to the issuing port only.
module ddr2_port_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 2
) (
    input logic                clk,
    input logic                rst,
    ddr2_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              read;
    } req_t;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t state_q;
    state_t state_d;

    req_t        mem [2][DEPTH];
    logic [PW:0] wp [2];
    logic [PW:0] rp [2];

    req_t       req_in [2];
    logic [1:0] en;
    logic [1:0] ne;
    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;

    logic gnt_vld;
    logic gnt;
    logic last_grant;
    logic cur_port;
    logic cur_read;
    req_t head;

    always_comb begin
        en = {bus.p1_enable, bus.p0_enable};
        req_in[0] = '{addr: bus.p0_addr,
                      data: bus.p0_write_data,
                      read: bus.p0_read};
        req_in[1] = '{addr: bus.p1_addr,
                      data: bus.p1_write_data,
                      read: bus.p1_read};
    end

    // Extra pointer bit distinguishes full from empty.
    always_comb begin
        ne   = '0;
        full = '0;
        for (int n = 0; n < 2; n++) begin
            ne[n]   = wp[n] != rp[n];
            full[n] = (wp[n][PW] != rp[n][PW]) &&
                      (wp[n][PW-1:0] == rp[n][PW-1:0]);
        end
    end

    always_comb begin
        push = en & ~full;
    end

    always_comb begin
        state_d = state_q;
        gnt_vld = 1'b0;
        gnt     = 1'b0;
        pop     = '0;
        unique case (state_q)
            IDLE: begin
                if (|ne) begin
                    gnt_vld  = 1'b1;
                    gnt      = (ne == 2'b11) ? ~last_grant : ne[1];
                    pop[gnt] = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (bus.ddr2_available)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign head     = mem[gnt][rp[gnt][PW-1:0]];
    assign bus.busy = (state_q == WAIT) || (|ne);

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int n = 0; n < 2; n++) begin
            if (push[n])
                mem[n][wp[n][PW-1:0]] <= req_in[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            wp[0]            <= '0;
            wp[1]            <= '0;
            rp[0]            <= '0;
            rp[1]            <= '0;
            last_grant       <= 1'b1;
            cur_port         <= 1'b0;
            cur_read         <= 1'b0;
            bus.overflow     <= '0;
            bus.ddr2_addr    <= '0;
            bus.to_ddr2_data <= '0;
            bus.ddr2_read    <= 1'b0;
            bus.ddr2_enable  <= 1'b0;
            bus.p0_data      <= '0;
            bus.p1_data      <= '0;
            bus.p0_available <= 1'b0;
            bus.p1_available <= 1'b0;
        end else begin
            state_q          <= state_d;
            bus.ddr2_enable  <= gnt_vld;
            bus.p0_available <= 1'b0;
            bus.p1_available <= 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (push[n])
                    wp[n] <= wp[n] + ONE;
                if (pop[n])
                    rp[n] <= rp[n] + ONE;
                if (en[n] && full[n])
                    bus.overflow[n] <= 1'b1;
            end
            if (gnt_vld) begin
                bus.ddr2_addr    <= head.addr;
                bus.to_ddr2_data <= head.data;
                bus.ddr2_read    <= head.read;
                cur_port         <= gnt;
                cur_read         <= head.read;
                last_grant       <= gnt;
            end
            // Write completions are absorbed here.
            if (state_q == WAIT && bus.ddr2_available && cur_read) begin
                if (cur_port) begin
                    bus.p1_data      <= bus.ddr2_data;
                    bus.p1_available <= 1'b1;
                end else begin
                    bus.p0_data      <= bus.ddr2_data;
                    bus.p0_available <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// Scoreboard bench for ddr2_port_arbiter with a fixed-latency DDR2 model.
// Expected commands and per-port read data are queued by the directed stimulus.
module tb_ddr2_port_arbiter;
    localparam int AW  = 27;
    localparam int DW  = 128;
    localparam int LAT = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rd;
        logic [DW-1:0] wd;
    } cmd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;

    always #5 clk = ~clk;

    ddr2_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr2_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    cmd_t          exp_cmd [$];
    logic [DW-1:0] exp_d0  [$];
    logic [DW-1:0] exp_d1  [$];
    logic [DW-1:0] mem [logic [AW-1:0]];
    int n_vec = 0;
    int n_err = 0;

    localparam logic [DW-1:0] A5 = {16{8'hA5}};

    task automatic check(input string name,
                         input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic exp_c(input logic [AW-1:0] a, input logic r,
                         input logic [DW-1:0] d);
        cmd_t c;
        c.addr = a;
        c.rd   = r;
        c.wd   = d;
        exp_cmd.push_back(c);
    endtask

    // DDR2 model: answers LAT negedges after seeing the command.
    initial begin : model
        int            cnt;
        logic          pend;
        logic [AW-1:0] ma;
        logic          mr;
        logic [DW-1:0] mw;
        pend = 1'b0;
        cnt  = 0;
        ma   = '0;
        mr   = 1'b0;
        mw   = '0;
        bus.ddr2_available = 1'b0;
        bus.ddr2_data      = '0;
        forever begin
            @(negedge clk);
            bus.ddr2_available = 1'b0;
            if (pend && !hold) begin
                if (cnt == 0) begin
                    bus.ddr2_available = 1'b1;
                    if (mr) begin
                        bus.ddr2_data = mem.exists(ma) ? mem[ma] : A5;
                    end else begin
                        mem[ma] = mw;
                        bus.ddr2_data = '0;
                    end
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (bus.ddr2_enable === 1'b1 && !rst) begin
                pend = 1'b1;
                cnt  = LAT - 1;
                ma   = bus.ddr2_addr;
                mr   = bus.ddr2_read;
                mw   = bus.to_ddr2_data;
            end
        end
    end

    initial begin : monitor
        cmd_t c;
        forever begin
            @(negedge clk);
            if (bus.ddr2_enable === 1'b1) begin
                if (exp_cmd.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cmd_unexpected: got addr %h want none",
                             bus.ddr2_addr);
                end else begin
                    c = exp_cmd.pop_front();
                    check("cmd_addr", bus.ddr2_addr, c.addr);
                    check("cmd_read", bus.ddr2_read, c.rd);
                    if (!c.rd)
                        check("cmd_wdata", bus.to_ddr2_data, c.wd);
                end
            end
            if (bus.p0_available === 1'b1) begin
                if (exp_d0.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL p0_unexpected: got %h want none",
                             bus.p0_data);
                end else begin
                    check("p0_data", bus.p0_data, exp_d0.pop_front());
                end
            end
            if (bus.p1_available === 1'b1) begin
                if (exp_d1.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL p1_unexpected: got %h want none",
                             bus.p1_data);
                end else begin
                    check("p1_data", bus.p1_data, exp_d1.pop_front());
                end
            end
        end
    end

    task automatic req(input int p, input logic [AW-1:0] a,
                       input logic r, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_enable = 1'b1;
            bus.p0_addr = a;
            bus.p0_read = r;
            bus.p0_write_data = d;
        end else begin
            bus.p1_enable = 1'b1;
            bus.p1_addr = a;
            bus.p1_read = r;
            bus.p1_write_data = d;
        end
        @(posedge clk);
        #1;
        bus.p0_enable = 1'b0;
        bus.p1_enable = 1'b0;
    endtask

    task automatic req_both(input logic [AW-1:0] a0,
                            input logic [AW-1:0] a1);
        bus.p0_enable = 1'b1;
        bus.p0_addr = a0;
        bus.p0_read = 1'b1;
        bus.p1_enable = 1'b1;
        bus.p1_addr = a1;
        bus.p1_read = 1'b1;
        @(posedge clk);
        #1;
        bus.p0_enable = 1'b0;
        bus.p1_enable = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((bus.busy || exp_cmd.size() != 0 || exp_d0.size() != 0 ||
                exp_d1.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check({name, "_timeout"}, k < 300, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_left"},
              exp_cmd.size() + exp_d0.size() + exp_d1.size(), 0);
    endtask

    task automatic check_zero(input string name);
        check({name, "_p0_data"}, bus.p0_data, '0);
        check({name, "_p1_data"}, bus.p1_data, '0);
        check({name, "_avail"}, {bus.p1_available, bus.p0_available}, '0);
        check({name, "_overflow"}, bus.overflow, '0);
        check({name, "_busy"}, bus.busy, 1'b0);
        check({name, "_ddr2_en"}, bus.ddr2_enable, 1'b0);
        check({name, "_ddr2_addr"}, bus.ddr2_addr, '0);
        check({name, "_ddr2_wd"}, bus.to_ddr2_data, '0);
        check({name, "_ddr2_rd"}, bus.ddr2_read, 1'b0);
    endtask

    task automatic single_read(input string name);
        exp_c(27'h0001230, 1'b1, '0);
        exp_d0.push_back(A5);
        req(0, 27'h0001230, 1'b1, '0);
        check({name, "_busy"}, bus.busy, 1'b1);
        check({name, "_en_pre"}, bus.ddr2_enable, 1'b0);
        @(posedge clk);
        #1;
        check({name, "_en_e1"}, bus.ddr2_enable, 1'b1);
        check({name, "_addr_e1"}, bus.ddr2_addr, 27'h0001230);
        drain(name);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] d1;
        bus.p0_addr = '0;
        bus.p1_addr = '0;
        bus.p0_write_data = '0;
        bus.p1_write_data = '0;
        bus.p0_enable = 1'b0;
        bus.p1_enable = 1'b0;
        bus.p0_read = 1'b0;
        bus.p1_read = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_zero("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_zero("rst_rel");

        single_read("s1");

        d1 = {32'hD1D1_0001, 32'hD1D1_0002, 32'hD1D1_0003, 32'hD1D1_0004};
        mem[27'h0007890] = {4{32'h7890_BEEF}};
        exp_c(27'h0004560, 1'b0, d1);
        exp_c(27'h0007890, 1'b1, '0);
        exp_d1.push_back({4{32'h7890_BEEF}});
        req(1, 27'h0004560, 1'b0, d1);
        req(1, 27'h0007890, 1'b1, '0);
        drain("s2");

        mem[27'h0000100] = {4{32'h0A0A_0100}};
        mem[27'h0000200] = {4{32'h1A1A_0200}};
        mem[27'h0000300] = {4{32'h0B0B_0300}};
        mem[27'h0000400] = {4{32'h1B1B_0400}};
        exp_c(27'h0000100, 1'b1, '0);
        exp_c(27'h0000200, 1'b1, '0);
        exp_c(27'h0000300, 1'b1, '0);
        exp_c(27'h0000400, 1'b1, '0);
        exp_d0.push_back({4{32'h0A0A_0100}});
        exp_d0.push_back({4{32'h0B0B_0300}});
        exp_d1.push_back({4{32'h1A1A_0200}});
        exp_d1.push_back({4{32'h1B1B_0400}});
        req_both(27'h0000100, 27'h0000200);
        req_both(27'h0000300, 27'h0000400);
        drain("s3");

        hold = 1'b1;
        mem[27'h0000510] = {4{32'h0000_0510}};
        exp_c(27'h0000500, 1'b1, '0);
        exp_c(27'h0000510, 1'b1, '0);
        exp_c(27'h0000520, 1'b1, '0);
        exp_d0.push_back(A5);
        exp_d0.push_back({4{32'h0000_0510}});
        exp_d0.push_back(A5);
        req(0, 27'h0000500, 1'b1, '0);
        req(0, 27'h0000510, 1'b1, '0);
        req(0, 27'h0000520, 1'b1, '0);
        check("ovf_before", bus.overflow, 2'b00);
        req(0, 27'h0000530, 1'b1, '0);
        check("ovf_after", bus.overflow, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_held", bus.overflow, 2'b01);
        check("ovf_busy", bus.busy, 1'b1);
        hold = 1'b0;
        drain("s4");
        check("ovf_sticky", bus.overflow, 2'b01);

        exp_c(27'h000ABC0, 1'b1, '0);
        req(0, 27'h000ABC0, 1'b1, '0);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_zero("rst_after");
        check("rst_cmds_left", exp_cmd.size(), 0);

        single_read("s5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ddr2_port_arbiter.md
# ddr2_port_arbiter

Shares the single DDR2 request/response interface between two cache-side requesters, e.g. instruction cache on port 0 and data cache on port 1. Each port takes one-cycle line requests (128-bit write-back or refill read) into a small per-port FIFO. The block grants the ports round-robin and keeps exactly one DDR2 transaction outstanding. Read data goes back only to the port that issued the read; write completions are absorbed, so a cache waiting on a refill never sees a write acknowledge.

## Interface
- `ADDR_W`, 27: byte address width (line aligned, low 4 bits passed through unchanged).
- `DATA_W`, 128: line width.
- `DEPTH`, 2: entries per port FIFO; power of two, ≥2.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `p0_addr`, `p1_addr` in ADDR_W: request address.
- `p0_write_data`, `p1_write_data` in DATA_W: write-back line; ignored for reads.
- `p0_enable`, `p1_enable` in 1: request strobe; each high cycle is one request.
- `p0_read`, `p1_read` in 1: 1 = refill read, 0 = write-back.
- `p0_data`, `p1_data` out DATA_W: returned read line, held until the next read completion on that port.
- `p0_available`, `p1_available` out 1: one-cycle pulse, read data valid.
- `overflow` out 2: sticky per port; set when a request arrives while that port's FIFO is full.
- `busy` out 1: high in WAIT or when either FIFO is non-empty.
- `ddr2_addr` out ADDR_W, `to_ddr2_data` out DATA_W, `ddr2_read` out 1: registered command fields.
- `ddr2_enable` out 1: one-cycle command pulse.
- `ddr2_available` in 1: one-cycle completion pulse from DDR2 controller, for reads and writes alike.
- `ddr2_data` in DATA_W: read line, valid with `ddr2_available`.

## Operation
- FIFOs: each port has a FIFO of {addr, write_data, read}.
  - A request pushes when `pN_enable`=1 and the FIFO is not full.
  - When full, the request is dropped and `overflow[N]` is set; it clears only on `rst`.
  - Push and pop on the same FIFO in the same cycle are both performed; occupancy is unchanged.
  - Per-port order is strict FIFO, so a write-back issued before a refill reaches DDR2 first.
- State IDLE:
  - If any FIFO is non-empty, grant a port.
    - Exactly one FIFO non-empty: grant that port.
    - Both non-empty: grant the port not granted last; `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant:
    - Pop the head entry.
    - Register `ddr2_addr`, `to_ddr2_data`, `ddr2_read` from it.
    - Set `ddr2_enable`<=1.
    - Record `cur_port` and `cur_read`; update `last_grant`.
    - Go to WAIT.
  - With both FIFOs empty, stay in IDLE.
- State WAIT:
  - `ddr2_enable`<=0 after its single high cycle.
  - `ddr2_addr`, `to_ddr2_data`, `ddr2_read` hold their values.
  - On `ddr2_available`=1 with `cur_read`=1: `p[cur_port]_data`<=`ddr2_data` and `p[cur_port]_available`<=1 for one cycle.
  - On `ddr2_available`=1 with `cur_read`=0: no port output changes.
  - Either case: go to IDLE.
- `ddr2_available` in IDLE is ignored.
- A request arriving on a port at the edge where its FIFO is empty is not bypassed; it is granted no earlier than the following edge.

## Timing
- Reset values:
  - Outputs: all 0, including `pN_data` and `ddr2_addr`/`to_ddr2_data`.
  - Internal: FIFOs empty, state IDLE, `last_grant`=1, `overflow`=0.
- Request latency:
  - `pN_enable` sampled at edge E0.
  - Grant at E1 at the earliest.
  - `ddr2_enable` high from E1 to E2.
- Completion latency:
  - `ddr2_available` sampled at edge Ec, the earliest being E2 (the same cycle `ddr2_enable` is high).
  - `pN_available` high from Ec to Ec+1.
  - The next grant is at Ec+1 at the earliest.
- Throughput: one DDR2 transaction per (controller latency + 1) cycles; the arbiter adds one idle-to-issue cycle per transaction.
- `rst` mid-operation:
  - Any outstanding transaction is abandoned and queued requests are discarded.
  - A `ddr2_available` that arrives after reset release lands in IDLE and is ignored.

## Test plan
- Single read, port 0: `p0_enable`=1, `p0_read`=1, addr 0x0001230 at E0; DDR2 model answers 3 cycles after the command with data 0xA5…A5.
  - Expect `ddr2_enable` one pulse at E1 with `ddr2_addr`=0x0001230 and `ddr2_read`=1.
  - Expect `p0_available` one pulse with `p0_data`=0xA5…A5; `p1_available` stays 0.
- Write-back then refill, port 1: write addr 0x0004560 data D1 at E0, read addr 0x0007890 at E0+1.
  - Expect two DDR2 commands in that order: write then read.
  - Expect exactly one `p1_available` pulse, after the read's completion.
- Contention: both ports issue reads at the same edge, then both issue again.
  - Expect DDR2 command order p0, p1, p0, p1.
  - Expect each `pN_available` pulse to carry that port's own data.
- Overflow, `DEPTH`=2: hold the DDR2 model's `ddr2_available` low and issue 4 port-0 reads on consecutive cycles.
  - Expect `overflow`=2'b01 from the 4th request onward: one entry in flight plus 2 queued, 4th dropped.
  - Expect exactly 3 port-0 completions once the DDR2 model is released.
- Reset in WAIT: assert `rst` one cycle after `ddr2_enable`; the DDR2 model then pulses `ddr2_available`.
  - Expect no `pN_available`, all outputs 0, and `busy`=0.
  - Expect a following request to behave as in scenario 1.
